// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: speculative register alias table with branch checkpoints, 1-cycle mispredict restore and committed-RAT recovery.
// Optional perf counters (perf_ckpt_full_stall, perf_mispredict) are built when RENAME_CKPT_PERF_EN is defined.
module rename_map_ckpt #(
    parameter int RENAME_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int ARF_SIZE = 32,
    parameter int PRF_SIZE = 64,
    parameter int CKPT_DEPTH = 4,
    localparam int PRF_IDX = $clog2(PRF_SIZE),
    localparam int ARF_IDX = $clog2(ARF_SIZE),
    localparam int TAG = $clog2(CKPT_DEPTH),
    localparam int SLOT_W = RENAME_WIDTH > 1 ? $clog2(RENAME_WIDTH) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            recover,
    input  logic [RENAME_WIDTH-1:0]         rn_valid,
    input  logic [RENAME_WIDTH-1:0]         rd_valid,
    input  logic [RENAME_WIDTH*ARF_IDX-1:0] rs1,
    input  logic [RENAME_WIDTH*ARF_IDX-1:0] rs2,
    input  logic [RENAME_WIDTH*ARF_IDX-1:0] rd,
    input  logic [RENAME_WIDTH*PRF_IDX-1:0] prd_in,
    input  logic                            ckpt_req,
    input  logic [SLOT_W-1:0]               ckpt_slot,
    output logic                            rn_accept,
    output logic [RENAME_WIDTH*PRF_IDX-1:0] prs1,
    output logic [RENAME_WIDTH*PRF_IDX-1:0] prs2,
    output logic [RENAME_WIDTH*PRF_IDX-1:0] prd,
    output logic [RENAME_WIDTH*PRF_IDX-1:0] prev_prd,
    output logic [TAG-1:0]                  ckpt_tag,
    output logic                            ckpt_full,
    input  logic                            br_valid,
    input  logic [TAG-1:0]                  br_tag,
    input  logic                            br_mispredict,
    input  logic [COMMIT_WIDTH-1:0]         retire_valid,
    input  logic [COMMIT_WIDTH*ARF_IDX-1:0] retire_arf,
    input  logic [COMMIT_WIDTH*PRF_IDX-1:0] retire_prf
`ifdef RENAME_CKPT_PERF_EN
    ,
    output logic [31:0]                     perf_ckpt_full_stall,
    output logic [31:0]                     perf_mispredict
`endif
);
    logic [PRF_IDX-1:0] map [ARF_SIZE];
    logic [PRF_IDX-1:0] crat [ARF_SIZE];
    logic [PRF_IDX-1:0] crat_next [ARF_SIZE];
    logic [PRF_IDX-1:0] snap [CKPT_DEPTH][ARF_SIZE];
    logic [PRF_IDX-1:0] stage [RENAME_WIDTH+1][ARF_SIZE];
    logic [RENAME_WIDTH-1:0] wr;
    logic [CKPT_DEPTH-1:0] valid, kill;
    logic [TAG:0] head, tail, tail_rb, drop;
    logic [TAG-1:0] br_off, k_off;
    logic mp;

    assign ckpt_full = (tail - head) == (TAG+1)'(CKPT_DEPTH);
    assign ckpt_tag = tail[TAG-1:0];
    assign mp = br_valid & br_mispredict & valid[br_tag];
    assign rn_accept = (|rn_valid) & ~stall & ~recover & ~(br_valid & br_mispredict) & ~(ckpt_req & ckpt_full);

    // Apply each slot's dest write in order; stage[i] is the map as seen by slot i
    always_comb begin
        stage[0] = map;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            wr[i] = rn_valid[i] & rd_valid[i] & (rd[i*ARF_IDX +: ARF_IDX] != '0);
            stage[i+1] = stage[i];
            if (wr[i]) stage[i+1][rd[i*ARF_IDX +: ARF_IDX]] = prd_in[i*PRF_IDX +: PRF_IDX];
        end
    end

    // Renamed operands, zero for empty slots or slots without a destination
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            prs1[i*PRF_IDX +: PRF_IDX] = rn_valid[i] ? stage[i][rs1[i*ARF_IDX +: ARF_IDX]] : '0;
            prs2[i*PRF_IDX +: PRF_IDX] = rn_valid[i] ? stage[i][rs2[i*ARF_IDX +: ARF_IDX]] : '0;
            prd[i*PRF_IDX +: PRF_IDX] = wr[i] ? prd_in[i*PRF_IDX +: PRF_IDX] : '0;
            prev_prd[i*PRF_IDX +: PRF_IDX] = wr[i] ? stage[i][rd[i*ARF_IDX +: ARF_IDX]] : '0;
        end
    end

    // Committed RAT after this cycle's retires; the higher slot wins, x0 stays pinned
    always_comb begin
        crat_next = crat;
        for (int c = 0; c < COMMIT_WIDTH; c++)
            if (retire_valid[c] && retire_arf[c*ARF_IDX +: ARF_IDX] != '0)
                crat_next[retire_arf[c*ARF_IDX +: ARF_IDX]] = retire_prf[c*PRF_IDX +: PRF_IDX];
    end

    // Mispredict rollback: tail returns to br_tag, which and everything younger is killed
    always_comb begin
        br_off = br_tag - head[TAG-1:0];
        tail_rb = head + {1'b0, br_off};
        drop = tail - tail_rb;
        k_off = '0;
        for (int k = 0; k < CKPT_DEPTH; k++) begin
            k_off = TAG'(k) - br_tag;
            kill[k] = {1'b0, k_off} < drop;
        end
    end

    // Map, committed RAT and checkpoint queue state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARF_SIZE; i++) begin
                map[i] <= PRF_IDX'(i);
                crat[i] <= PRF_IDX'(i);
            end
            valid <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            crat <= crat_next;
            if (recover) begin
                map <= crat_next;
                valid <= '0;
                head <= '0;
                tail <= '0;
            end else if (mp) begin
                map <= snap[br_tag];
                valid <= valid & ~kill;
                tail <= tail_rb;
            end else begin
                if (rn_accept) map <= stage[RENAME_WIDTH];
                if (br_valid) valid[br_tag] <= 1'b0;
                if (rn_accept && ckpt_req) begin
                    snap[tail[TAG-1:0]] <= stage[int'(ckpt_slot) + 1];
                    valid[tail[TAG-1:0]] <= 1'b1;
                    tail <= tail + 1'b1;
                end
                if (head != tail && !valid[head[TAG-1:0]]) head <= head + 1'b1;
            end
        end
    end

`ifdef RENAME_CKPT_PERF_EN
    // Saturating event counters for checkpoint-full stalls and taken mispredicts
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ckpt_full_stall <= '0;
            perf_mispredict <= '0;
        end else begin
            if (ckpt_req && ckpt_full && |rn_valid && ~&perf_ckpt_full_stall)
                perf_ckpt_full_stall <= perf_ckpt_full_stall + 1'b1;
            if (mp && !recover && ~&perf_mispredict) perf_mispredict <= perf_mispredict + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rename_map_ckpt.sv
// tb_rename_map_ckpt: scoreboard bench for rename_map_ckpt covering rename, forwarding, checkpoints, mispredict, retire and recover.
module tb_rename_map_ckpt;
    localparam int AI = 5, PI = 6;
    localparam int O_ACC = 0, O_TAG = 1, O_FULL = 2, O_PRD0 = 3, O_PRD1 = 4, O_PREV0 = 5, O_PREV1 = 6;
    localparam int O_PRS1_0 = 7, O_PRS1_1 = 8, O_PRS2_1 = 9;

    logic clock = 1'b0;
    logic reset, stall, recover, ckpt_req, br_valid, br_mispredict;
    logic [1:0] rn_valid, rd_valid, retire_valid, br_tag, ckpt_tag;
    logic [0:0] ckpt_slot;
    logic [2*AI-1:0] rs1, rs2, rd, retire_arf;
    logic [2*PI-1:0] prd_in, prs1, prs2, prd, prev_prd, retire_prf;
    logic rn_accept, ckpt_full;

    typedef struct {
        int code;
        logic [31:0] val;
        string tag;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    rename_map_ckpt dut (
        .clock(clock), .reset(reset), .stall(stall), .recover(recover),
        .rn_valid(rn_valid), .rd_valid(rd_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
        .prd_in(prd_in), .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot),
        .rn_accept(rn_accept), .prs1(prs1), .prs2(prs2), .prd(prd), .prev_prd(prev_prd),
        .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
        .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
        .retire_valid(retire_valid), .retire_arf(retire_arf), .retire_prf(retire_prf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs(input int code);
        case (code)
            O_ACC:    return 32'(rn_accept);
            O_TAG:    return 32'(ckpt_tag);
            O_FULL:   return 32'(ckpt_full);
            O_PRD0:   return 32'(prd[0 +: PI]);
            O_PRD1:   return 32'(prd[PI +: PI]);
            O_PREV0:  return 32'(prev_prd[0 +: PI]);
            O_PREV1:  return 32'(prev_prd[PI +: PI]);
            O_PRS1_0: return 32'(prs1[0 +: PI]);
            O_PRS1_1: return 32'(prs1[PI +: PI]);
            O_PRS2_1: return 32'(prs2[PI +: PI]);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int code, input int val);
        exp_t e;
        e.code = code;
        e.val = 32'(val);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic clr();
        stall = 0; recover = 0; ckpt_req = 0; ckpt_slot = 0;
        br_valid = 0; br_mispredict = 0; br_tag = 0;
        rn_valid = 0; rd_valid = 0; rs1 = 0; rs2 = 0; rd = 0; prd_in = 0;
        retire_valid = 0; retire_arf = 0; retire_prf = 0;
    endtask

    task automatic slot(input int i, input int s1, input int s2, input int d, input bit de, input int p);
        rn_valid[i] = 1'b1;
        rd_valid[i] = de;
        rs1[i*AI +: AI] = AI'(s1);
        rs2[i*AI +: AI] = AI'(s2);
        rd[i*AI +: AI] = AI'(d);
        prd_in[i*PI +: PI] = PI'(p);
    endtask

    // Compare queued expectations against settled outputs, then advance one clock
    task automatic cyc();
        exp_t e;
        @(negedge clock);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.code), e.val);
        end
        @(posedge clock);
        #1;
        clr();
    endtask

    // Read the speculative map through slot 0 without changing it
    task automatic observe(input int r, input int want, input string tag);
        stall = 1;
        slot(0, r, 0, 0, 0, 0);
        push_exp(tag, O_PRS1_0, want);
        push_exp({tag, "_acc"}, O_ACC, 0);
        cyc();
    endtask

    initial begin
        clr();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        push_exp("rst_acc", O_ACC, 0);
        push_exp("rst_prd", O_PRD0, 0);
        push_exp("rst_prev", O_PREV0, 0);
        push_exp("rst_full", O_FULL, 0);
        cyc();
        observe(4, 4, "rst_map4");

        slot(0, 0, 0, 5, 1, 40);
        push_exp("r5_acc", O_ACC, 1);
        push_exp("r5_prd", O_PRD0, 40);
        push_exp("r5_prev", O_PREV0, 5);
        cyc();
        slot(0, 5, 0, 0, 0, 0);
        push_exp("r5_src", O_PRS1_0, 40);
        cyc();

        slot(0, 0, 0, 3, 1, 41);
        slot(1, 3, 5, 3, 1, 42);
        push_exp("grp_prev0", O_PREV0, 3);
        push_exp("grp_fwd_prs1", O_PRS1_1, 41);
        push_exp("grp_map_prs2", O_PRS2_1, 40);
        push_exp("grp_prev1", O_PREV1, 41);
        push_exp("grp_prd1", O_PRD1, 42);
        cyc();
        observe(3, 42, "dup_rd_youngest");

        slot(0, 0, 0, 0, 0, 0);
        slot(1, 0, 0, 7, 1, 50);
        ckpt_req = 1;
        ckpt_slot = 0;
        push_exp("ck_acc", O_ACC, 1);
        push_exp("ck_tag", O_TAG, 0);
        push_exp("ck_prev1", O_PREV1, 7);
        cyc();
        observe(7, 50, "ck_spec_map7");
        br_valid = 1;
        br_mispredict = 1;
        br_tag = 0;
        slot(0, 0, 0, 7, 1, 60);
        push_exp("mp_acc", O_ACC, 0);
        cyc();
        observe(7, 7, "mp_restore7");
        observe(5, 40, "mp_keep5");
        observe(3, 42, "mp_keep3");

        for (int t = 0; t < 4; t++) begin
            slot(0, 0, 0, 0, 0, 0);
            ckpt_req = 1;
            push_exp($sformatf("alloc%0d_acc", t), O_ACC, 1);
            push_exp($sformatf("alloc%0d_tag", t), O_TAG, t);
            push_exp($sformatf("alloc%0d_full", t), O_FULL, 0);
            cyc();
        end
        slot(0, 0, 0, 0, 0, 0);
        ckpt_req = 1;
        push_exp("full_flag", O_FULL, 1);
        push_exp("full_block", O_ACC, 0);
        cyc();
        br_valid = 1;
        br_tag = 0;
        cyc();
        cyc();
        slot(0, 0, 0, 0, 0, 0);
        ckpt_req = 1;
        push_exp("rel0_full", O_FULL, 0);
        push_exp("rel0_acc", O_ACC, 1);
        push_exp("rel0_tag", O_TAG, 0);
        cyc();

        br_valid = 1;
        br_tag = 2;
        cyc();
        cyc();
        cyc();
        slot(0, 0, 0, 0, 0, 0);
        ckpt_req = 1;
        push_exp("ooo_rel_full", O_FULL, 1);
        push_exp("ooo_rel_block", O_ACC, 0);
        cyc();
        br_valid = 1;
        br_tag = 1;
        cyc();
        cyc();
        cyc();
        slot(0, 0, 0, 0, 0, 0);
        ckpt_req = 1;
        push_exp("rel1_full", O_FULL, 0);
        push_exp("rel1_acc", O_ACC, 1);
        push_exp("rel1_tag", O_TAG, 1);
        cyc();

        stall = 1;
        slot(0, 0, 0, 10, 1, 34);
        retire_valid = 2'b11;
        retire_arf = {5'd10, 5'd10};
        retire_prf = {6'd44, 6'd43};
        push_exp("stall_acc", O_ACC, 0);
        push_exp("stall_prd", O_PRD0, 34);
        cyc();
        observe(10, 10, "stall_map_hold");

        recover = 1;
        retire_valid = 2'b01;
        retire_arf = {5'd0, 5'd9};
        retire_prf = {6'd0, 6'd55};
        slot(0, 0, 0, 12, 1, 35);
        push_exp("rec_acc", O_ACC, 0);
        cyc();
        observe(9, 55, "rec_same_cycle_retire");
        observe(10, 44, "rec_retire_hi_slot");
        observe(5, 5, "rec_drop_spec");
        slot(0, 0, 0, 0, 0, 0);
        ckpt_req = 1;
        push_exp("rec_full", O_FULL, 0);
        push_exp("rec_ck_acc", O_ACC, 1);
        push_exp("rec_ck_tag", O_TAG, 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
